// File: rtl/bs_link_pkg.sv
// Shared types and helpers for the Battleship board-to-board serial link.
package bs_link_pkg;

    // Widest payload the parity helper accepts; narrower words are zero-extended,
    // which leaves the parity of the word unchanged.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SHIFT,
        TX_GAP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SAMPLE,
        RX_CHECK
    } rx_state_t;

    // Even-parity bit: makes the total count of ones in {parity, data} even.
    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] data);
        return ^data;
    endfunction

    // Bits needed to hold a counter whose largest value is max_val (at least 1).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bs_link_if.sv
// Word-level handshake bundle between the game logic and the link port.
interface bs_link_if
    import bs_link_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_busy;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ack;
    logic             rx_parity_err;
    logic             rx_frame_err;
    logic             rx_overrun;

    // Game-side view: produces transmit words, consumes received words.
    modport master (
        output tx_data, tx_valid, rx_ack,
        input  tx_ready, tx_busy, rx_data, rx_valid,
        input  rx_parity_err, rx_frame_err, rx_overrun
    );

    // Link-port view.
    modport slave (
        input  tx_data, tx_valid, rx_ack,
        output tx_ready, tx_busy, rx_data, rx_valid,
        output rx_parity_err, rx_frame_err, rx_overrun
    );
endinterface

// File: rtl/bs_link_fifo.sv
// Synchronous first-word-fall-through FIFO holding words waiting to be sent.
module bs_link_fifo
    import bs_link_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    // A push into a full FIFO is ignored; tx_ready already reads 0 then.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!clr_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; the flushed pointers make stale contents unreachable.
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/bs_link_port.sv
// Full-duplex serial endpoint: queued transmitter and checked receiver for the
// Battleship master/slave link. Frame = payload LSB first, then optional even parity,
// framed by sig_out high; at least GAP_BITS idle bit periods between frames.
module bs_link_port
    import bs_link_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 100,
    parameter int TXQ_DEPTH    = 4,
    parameter int PARITY_EN    = 1,
    parameter int GAP_BITS     = 1
) (
    input  logic      clk,
    input  logic      clr_n,
    bs_link_if.slave  bus,
    output logic      bs_out,
    output logic      sig_out,
    input  logic      bs_in,
    input  logic      sig_in
);
    localparam int NB = WIDTH + ((PARITY_EN != 0) ? 1 : 0);
    // Keep at least one idle bit period so the peer always sees the envelope fall.
    localparam int GAP_CYC = ((GAP_BITS > 0) ? GAP_BITS : 1) * CLKS_PER_BIT;
    localparam int CW = cnt_w(CLKS_PER_BIT - 1);
    localparam int BW = cnt_w(NB - 1);
    localparam int GW = cnt_w(GAP_CYC - 1);
    localparam logic [CW-1:0] CYC_LAST    = CW'(CLKS_PER_BIT - 1);
    // Preloading the cycle counter puts the first sample half a bit after frame start.
    localparam logic [CW-1:0] RX_CYC_INIT = CW'(CLKS_PER_BIT - CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] BIT_LAST    = BW'(NB - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYC - 1);

    // ---------------- transmit side ----------------
    tx_state_t        r_tx_state;
    logic [NB-1:0]    r_tx_sh;
    logic [BW-1:0]    r_tx_bit;
    logic [CW-1:0]    r_tx_cyc;
    logic [GW-1:0]    r_gap_cyc;
    logic             r_bs_out;
    logic             r_sig_out;
    logic [WIDTH-1:0] w_fifo_data;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_fifo_pop;
    logic [NB-1:0]    w_tx_frame;

    assign w_fifo_pop = (r_tx_state == TX_LOAD);
    // With parity disabled the cast drops the parity bit and leaves the bare payload.
    assign w_tx_frame = NB'({even_parity(MAX_WIDTH'(w_fifo_data)), w_fifo_data});

    bs_link_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (TXQ_DEPTH)
    ) u_txq (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_push  (bus.tx_valid),
        .i_data  (bus.tx_data),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign bus.tx_ready = !w_fifo_full;
    assign bus.tx_busy  = (r_tx_state != TX_IDLE) || !w_fifo_empty;
    assign bs_out       = r_bs_out;
    assign sig_out      = r_sig_out;

    // Transmit FSM: pop a word, shift it out one bit period per bit, then hold the gap.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_sh    <= '0;
            r_tx_bit   <= '0;
            r_tx_cyc   <= '0;
            r_gap_cyc  <= '0;
            r_bs_out   <= 1'b0;
            r_sig_out  <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (!w_fifo_empty) r_tx_state <= TX_LOAD;
                end
                TX_LOAD: begin
                    r_tx_sh    <= w_tx_frame;
                    r_bs_out   <= w_tx_frame[0];
                    r_sig_out  <= 1'b1;
                    r_tx_bit   <= '0;
                    r_tx_cyc   <= '0;
                    r_tx_state <= TX_SHIFT;
                end
                TX_SHIFT: begin
                    if (r_tx_cyc == CYC_LAST) begin
                        r_tx_cyc <= '0;
                        if (r_tx_bit == BIT_LAST) begin
                            r_bs_out   <= 1'b0;
                            r_sig_out  <= 1'b0;
                            r_gap_cyc  <= '0;
                            r_tx_state <= TX_GAP;
                        end else begin
                            r_tx_bit <= r_tx_bit + BW'(1);
                            r_tx_sh  <= r_tx_sh >> 1;
                            r_bs_out <= r_tx_sh[1];
                        end
                    end else begin
                        r_tx_cyc <= r_tx_cyc + CW'(1);
                    end
                end
                TX_GAP: begin
                    if (r_gap_cyc == GAP_LAST) begin
                        r_tx_state <= w_fifo_empty ? TX_IDLE : TX_LOAD;
                    end else begin
                        r_gap_cyc <= r_gap_cyc + GW'(1);
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receive side ----------------
    rx_state_t        r_rx_state;
    logic [1:0]       r_sig_sync;
    logic [1:0]       r_bs_sync;
    logic             r_sig_prev;
    logic [NB-1:0]    r_rx_sh;
    logic [BW-1:0]    r_rx_bit;
    logic [CW-1:0]    r_rx_cyc;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_parity_err;
    logic             r_frame_err;
    logic             r_overrun;
    logic             w_sig_s;
    logic             w_bs_s;
    logic             w_rx_start;
    logic [WIDTH-1:0] w_rx_word;
    logic             w_par_ok;

    assign w_sig_s    = r_sig_sync[1];
    assign w_bs_s     = r_bs_sync[1];
    assign w_rx_start = w_sig_s && !r_sig_prev;
    assign w_rx_word  = r_rx_sh[WIDTH-1:0];
    assign w_par_ok   = (PARITY_EN == 0) ||
                        (r_rx_sh[NB-1] == even_parity(MAX_WIDTH'(w_rx_word)));

    assign bus.rx_data       = r_rx_data;
    assign bus.rx_valid      = r_rx_valid;
    assign bus.rx_parity_err = r_parity_err;
    assign bus.rx_frame_err  = r_frame_err;
    assign bus.rx_overrun    = r_overrun;

    // Two-flop synchronisers for the asynchronous peer pins, plus envelope edge history.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_sig_sync <= '0;
            r_bs_sync  <= '0;
            r_sig_prev <= 1'b0;
        end else begin
            r_sig_sync <= {r_sig_sync[0], sig_in};
            r_bs_sync  <= {r_bs_sync[0], bs_in};
            r_sig_prev <= r_sig_sync[1];
        end
    end

    // Receive FSM: mid-bit sampling, envelope-loss detection, parity check and hand-off.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_rx_state   <= RX_IDLE;
            r_rx_sh      <= '0;
            r_rx_bit     <= '0;
            r_rx_cyc     <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            // An ack drops rx_valid; a load in CHECK below overrides this (last write wins).
            if (bus.rx_ack) r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_start) begin
                        r_rx_cyc   <= RX_CYC_INIT;
                        r_rx_bit   <= '0;
                        r_rx_state <= RX_SAMPLE;
                    end
                end
                RX_SAMPLE: begin
                    if (!w_sig_s) begin
                        r_frame_err <= 1'b1;
                        r_rx_state  <= RX_IDLE;
                    end else if (r_rx_cyc == CYC_LAST) begin
                        r_rx_cyc <= '0;
                        r_rx_sh  <= {w_bs_s, r_rx_sh[NB-1:1]};
                        if (r_rx_bit == BIT_LAST) begin
                            r_rx_state <= RX_CHECK;
                        end else begin
                            r_rx_bit <= r_rx_bit + BW'(1);
                        end
                    end else begin
                        r_rx_cyc <= r_rx_cyc + CW'(1);
                    end
                end
                RX_CHECK: begin
                    r_rx_state <= RX_IDLE;
                    if (!w_par_ok) begin
                        r_parity_err <= 1'b1;
                    end else if (!r_rx_valid || bus.rx_ack) begin
                        r_rx_data  <= w_rx_word;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bs_link_port.sv
// Loopback bench for bs_link_port: directed scenarios plus a randomized stream,
// checked against a word queue and frame rules computed from first principles.
module tb_bs_link_port;
    localparam int WIDTH     = 16;
    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int PAR       = 1;
    localparam int GAPB      = 1;
    localparam int FRAME_CYC = (WIDTH + PAR) * CPB;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    logic bs_out, sig_out, bs_in, sig_in;
    logic flip = 1'b0;
    logic kill = 1'b0;

    always #5 clk = ~clk;

    bs_link_if #(.WIDTH(WIDTH)) bus ();

    assign bs_in  = bs_out ^ flip;
    assign sig_in = sig_out & ~kill;

    bs_link_port #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CPB),
        .TXQ_DEPTH    (DEPTH),
        .PARITY_EN    (PAR),
        .GAP_BITS     (GAPB)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .bus     (bus),
        .bs_out  (bs_out),
        .sig_out (sig_out),
        .bs_in   (bs_in),
        .sig_in  (sig_in)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_rx = '0;

    // Passive monitor, sampled 1 time unit after each rising edge.
    int sig_rises = 0, cur_run = 0, last_run = 0, pe_cycles = 0, fe_cycles = 0;
    always @(posedge clk) begin
        #1;
        if (sig_out) begin
            if (cur_run == 0) sig_rises++;
            cur_run++;
        end else if (cur_run != 0) begin
            last_run = cur_run;
            cur_run  = 0;
        end
        if (bus.rx_parity_err) pe_cycles++;
        if (bus.rx_frame_err)  fe_cycles++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached (n_cmp=%0d)", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Offer one word and hold it until the port accepts it.
    task automatic push(input logic [15:0] w, input bit expect_rx);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (bus.tx_ready) begin
                @(negedge clk);
                bus.tx_valid = 1'b0;
                if (expect_rx) exp_q.push_back(w);
                return;
            end
            @(negedge clk);
        end
        bus.tx_valid = 1'b0;
        check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_sig(input logic lvl, input string tag);
        for (int i = 0; i < 1000; i++) begin
            if (sig_out === lvl) return;
            @(negedge clk);
        end
        check({tag, "_sig_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rx(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (bus.rx_valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check({tag, "_rx_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (!bus.tx_busy) begin
                tick(8);
                return;
            end
            @(negedge clk);
        end
        check({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    // Receive one word, compare against the oldest expected word, then acknowledge it.
    task automatic recv(input string tag, input int dly);
        bit ok;
        logic [15:0] e;
        wait_rx(tag, ok);
        if (ok) begin
            tick(dly);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            check({tag, "_data"}, bus.rx_data, e);
            last_rx = e;
            bus.rx_ack = 1'b1;
            tick(1);
            bus.rx_ack = 1'b0;
            check({tag, "_valid_clr"}, bus.rx_valid, 32'd0);
        end
    endtask

    logic [15:0] w;
    logic [16:0] fr;
    int pe0, fe0, rises0, first_block, d_rx;
    bit ok;

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.rx_ack   = 1'b0;
        clr_n        = 1'b0;
        tick(3);

        // Reset state
        check("rst_tx_ready", bus.tx_ready, 32'd1);
        check("rst_tx_busy",  bus.tx_busy,  32'd0);
        check("rst_sig_out",  sig_out,      32'd0);
        check("rst_bs_out",   bs_out,       32'd0);
        check("rst_rx_valid", bus.rx_valid, 32'd0);
        check("rst_rx_data",  bus.rx_data,  32'd0);
        check("rst_overrun",  bus.rx_overrun, 32'd0);
        clr_n = 1'b1;
        tick(2);

        // 1: single word, latency, wire bit pattern, envelope length
        pe0 = pe_cycles; fe0 = fe_cycles;
        w  = 16'hA5C3;
        fr = {1'(($countones(w) % 2) != 0), w};
        bus.tx_data = w; bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
        exp_q.push_back(w);
        check("t1_sig_n0", sig_out, 32'd0);
        tick(1);
        check("t1_sig_n1", sig_out, 32'd0);
        tick(1);
        check("t1_sig_n2", sig_out, 32'd1);
        tick(1);
        check("t1_bit0", bs_out, {31'd0, fr[0]});
        for (int k = 1; k < WIDTH + PAR; k++) begin
            tick(CPB);
            check($sformatf("t1_bit%0d", k), bs_out, {31'd0, fr[k]});
        end
        recv("t1", 0);
        wait_idle("t1");
        check("t1_sig_len", last_run, FRAME_CYC);
        check("t1_no_perr", pe_cycles - pe0, 32'd0);
        check("t1_no_ferr", fe_cycles - fe0, 32'd0);

        // 2: six words back-to-back; queue fills after five acceptances
        first_block = -1;
        fork
            begin
                int acc = 0;
                for (int n = 1; n <= 6; n++) begin
                    bus.tx_data  = 16'(n);
                    bus.tx_valid = 1'b1;
                    for (int t = 0; t < 2000 && !bus.tx_ready; t++) begin
                        if (first_block < 0) first_block = acc;
                        @(negedge clk);
                    end
                    @(negedge clk);
                    exp_q.push_back(16'(n));
                    acc++;
                end
                bus.tx_valid = 1'b0;
            end
            begin
                for (int n = 0; n < 6; n++) recv("t2", 0);
            end
        join
        check("t2_accepted_before_full", first_block, 32'd5);
        wait_idle("t2");

        // 3: corrupt the parity bit period of 16'h00FF
        pe0 = pe_cycles; fe0 = fe_cycles;
        push(16'h00FF, 1'b0);
        wait_sig(1'b1, "t3");
        tick((WIDTH + PAR - 1) * CPB);
        flip = 1'b1;
        tick(CPB);
        flip = 1'b0;
        wait_idle("t3");
        check("t3_perr_pulse", pe_cycles - pe0, 32'd1);
        check("t3_no_ferr",    fe_cycles - fe0, 32'd0);
        check("t3_rx_valid",   bus.rx_valid, 32'd0);
        check("t3_rx_data",    bus.rx_data,  {16'd0, last_rx});

        // 4a: two frames, no ack -> first word kept, overrun set
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b0);
        wait_sig(1'b1, "t4a");
        d_rx = 0;
        for (int i = 0; i < 600 && !bus.rx_valid; i++) begin
            tick(1);
            d_rx++;
        end
        check("t4_rx_latency_window",
              {31'd0, (d_rx > FRAME_CYC) && (d_rx <= FRAME_CYC + 8)}, 32'd1);
        wait_idle("t4a");
        check("t4a_rx_data",  bus.rx_data,    32'h1111);
        check("t4a_rx_valid", bus.rx_valid,   32'd1);
        check("t4a_overrun",  bus.rx_overrun, 32'd1);

        // 4b: after reset, ack coincides with the second word's load
        clr_n = 1'b0;
        tick(1);
        clr_n = 1'b1;
        tick(1);
        check("t4b_overrun_rst", bus.rx_overrun, 32'd0);
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b0);
        wait_rx("t4b", ok);
        wait_sig(1'b0, "t4b");
        wait_sig(1'b1, "t4b");
        tick(d_rx - 1);
        check("t4b_valid_held", bus.rx_valid, 32'd1);
        bus.rx_ack = 1'b1;
        tick(1);
        bus.rx_ack = 1'b0;
        check("t4b_rx_data",  bus.rx_data,    32'h2222);
        check("t4b_rx_valid", bus.rx_valid,   32'd1);
        check("t4b_overrun",  bus.rx_overrun, 32'd0);
        exp_q.push_back(16'h2222);
        recv("t4b_drain", 0);
        wait_idle("t4b");

        // 5: envelope lost after 8 bit periods, then a clean frame
        pe0 = pe_cycles; fe0 = fe_cycles;
        push(16'($urandom), 1'b0);
        wait_sig(1'b1, "t5");
        tick(8 * CPB);
        kill = 1'b1;
        wait_sig(1'b0, "t5");
        tick(2);
        kill = 1'b0;
        tick(4);
        check("t5_ferr_pulse", fe_cycles - fe0, 32'd1);
        check("t5_no_perr",    pe_cycles - pe0, 32'd0);
        check("t5_rx_valid",   bus.rx_valid, 32'd0);
        wait_idle("t5");
        push(16'($urandom), 1'b1);
        recv("t5_next", 0);
        wait_idle("t5_next");

        // Randomized stream with random producer gaps and consumer ack delays
        pe0 = pe_cycles; fe0 = fe_cycles;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    tick($urandom_range(0, 3));
                    push(16'($urandom), 1'b1);
                end
            end
            begin
                for (int i = 0; i < 8; i++) recv("rnd", $urandom_range(0, 30));
            end
        join
        wait_idle("rnd");
        check("rnd_no_overrun", bus.rx_overrun, 32'd0);
        check("rnd_no_perr",    pe_cycles - pe0, 32'd0);
        check("rnd_no_ferr",    fe_cycles - fe0, 32'd0);

        // 6: reset mid-frame with a word pending and more queued
        push(16'h5A5A, 1'b0);
        wait_rx("t6", ok);
        push(16'h0101, 1'b0);
        push(16'h0202, 1'b0);
        push(16'h0303, 1'b0);
        wait_sig(1'b1, "t6");
        tick(20);
        clr_n = 1'b0;
        tick(1);
        clr_n = 1'b1;
        check("t6_sig_out",  sig_out,        32'd0);
        check("t6_bs_out",   bs_out,         32'd0);
        check("t6_tx_ready", bus.tx_ready,   32'd1);
        check("t6_tx_busy",  bus.tx_busy,    32'd0);
        check("t6_rx_valid", bus.rx_valid,   32'd0);
        check("t6_rx_data",  bus.rx_data,    32'd0);
        check("t6_overrun",  bus.rx_overrun, 32'd0);
        rises0 = sig_rises;
        tick(4 * FRAME_CYC);
        check("t6_queue_flushed", sig_rises - rises0, 32'd0);
        check("t6_still_idle",    bus.tx_busy,  32'd0);
        check("t6_no_rx",         bus.rx_valid, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
